// File: rtl/input_conditioner_pkg.sv
// Shared sizing for the board input conditioner: button/switch counts and default debounce time.
// No logic; constants only.
// Not applicable (no handshake).
package input_conditioner_pkg;
    localparam int N_BTN                   = 2;
    localparam int N_SW                    = 10;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
endpackage

// File: rtl/input_conditioner_debounce_bit.sv
// One raw input: two-flop synchronizer, stability counter, stable flop and edge pulses.
// Stable output follows a held input DEBOUNCE_CYCLES+2 edges after it settles.
// No backpressure; pulses are single-cycle and cannot be stalled.
module debounce_bit
    import input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);
    localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_stable;
    logic          r_rise;
    logic          r_fall;
    logic [CW-1:0] r_cnt;
    logic          w_differs;
    logic          w_expire;

    assign w_differs = r_sync2 ^ r_stable;
    assign w_expire  = w_differs && (r_cnt == CNT_MAX);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            // Pulses are produced on the same edge as the stable flop so they line up with it.
            r_rise  <= w_expire && r_sync2;
            r_fall  <= w_expire && !r_sync2;
            if (w_expire) begin
                r_stable <= r_sync2;
            end
            if (!w_differs || w_expire) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_stable;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;
endmodule

// File: rtl/input_conditioner.sv
// Debounces active-low push buttons and slide switches; emits levels and edge pulses.
// Latency DEBOUNCE_CYCLES+2 edges from a settled input to the stable output and pulses.
// No backpressure; every output is a level or a one-cycle pulse.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic             CLK1,
    input  logic             RST,
    input  logic [N_BTN-1:0] BTN,
    input  logic [N_SW-1:0]  SW,
    output logic [N_BTN-1:0] BTN_LEVEL,
    output logic [N_BTN-1:0] BTN_PRESS,
    output logic [N_BTN-1:0] BTN_RELEASE,
    output logic [N_SW-1:0]  SW_STABLE,
    output logic [N_SW-1:0]  SW_DELTA,
    output logic             SW_CHANGE
);
    logic [N_BTN-1:0] w_btn_act;
    logic [N_SW-1:0]  w_sw_rise;
    logic [N_SW-1:0]  w_sw_fall;

    // Buttons pull low when pressed; invert so 1 means pressed everywhere downstream.
    assign w_btn_act = ~BTN;

    for (genvar g = 0; g < N_BTN; g++) begin : g_btn
        debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .i_clk  (CLK1),
            .i_rst  (RST),
            .i_raw  (w_btn_act[g]),
            .o_level(BTN_LEVEL[g]),
            .o_rise (BTN_PRESS[g]),
            .o_fall (BTN_RELEASE[g])
        );
    end

    for (genvar g = 0; g < N_SW; g++) begin : g_sw
        debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .i_clk  (CLK1),
            .i_rst  (RST),
            .i_raw  (SW[g]),
            .o_level(SW_STABLE[g]),
            .o_rise (w_sw_rise[g]),
            .o_fall (w_sw_fall[g])
        );
    end

    assign SW_DELTA  = w_sw_rise | w_sw_fall;
    assign SW_CHANGE = |SW_DELTA;
endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner at DEBOUNCE_CYCLES=4; expected outputs queued per cycle.
module tb_input_conditioner;
    localparam int DC  = 4;
    localparam int LAT = DC + 2;

    logic       CLK1 = 1'b0;
    logic       RST;
    logic [1:0] BTN;
    logic [9:0] SW;
    logic [1:0] BTN_LEVEL, BTN_PRESS, BTN_RELEASE;
    logic [9:0] SW_STABLE, SW_DELTA;
    logic       SW_CHANGE;

    input_conditioner #(.DEBOUNCE_CYCLES(DC)) dut (
        .CLK1       (CLK1),
        .RST        (RST),
        .BTN        (BTN),
        .SW         (SW),
        .BTN_LEVEL  (BTN_LEVEL),
        .BTN_PRESS  (BTN_PRESS),
        .BTN_RELEASE(BTN_RELEASE),
        .SW_STABLE  (SW_STABLE),
        .SW_DELTA   (SW_DELTA),
        .SW_CHANGE  (SW_CHANGE)
    );

    always #10 CLK1 = ~CLK1;

    int cyc = 0;
    always @(posedge CLK1) cyc++;

    typedef struct {
        int         cyc;
        logic [1:0] lvl;
        logic [1:0] press;
        logic [1:0] rel;
        logic [9:0] sw;
        logic [9:0] delta;
        logic       chg;
    } exp_t;

    exp_t       q[$];
    logic [1:0] cur_lvl, fut_lvl;
    logic [9:0] cur_sw, fut_sw;
    int         tests = 0;
    int         fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv)
        else begin
            fails++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
        end
    endtask

    task automatic check_cycle();
        exp_t e;
        if (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
        end else begin
            e.cyc   = cyc;
            e.lvl   = cur_lvl;
            e.press = '0;
            e.rel   = '0;
            e.sw    = cur_sw;
            e.delta = '0;
            e.chg   = 1'b0;
        end
        cur_lvl = e.lvl;
        cur_sw  = e.sw;
        chk("btn_level",   32'(BTN_LEVEL),   32'(e.lvl));
        chk("btn_press",   32'(BTN_PRESS),   32'(e.press));
        chk("btn_release", 32'(BTN_RELEASE), 32'(e.rel));
        chk("sw_stable",   32'(SW_STABLE),   32'(e.sw));
        chk("sw_delta",    32'(SW_DELTA),    32'(e.delta));
        chk("sw_change",   32'(SW_CHANGE),   32'(e.chg));
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK1);
            @(negedge CLK1);
            check_cycle();
        end
    endtask

    // Drive a new settled input pattern and queue the outputs it must produce LAT edges later.
    task automatic apply(input logic [1:0] btn, input logic [9:0] sw);
        exp_t       e;
        logic [1:0] nl;
        nl      = ~btn;
        e.cyc   = cyc + LAT;
        e.lvl   = nl;
        e.press = nl & ~fut_lvl;
        e.rel   = ~nl & fut_lvl;
        e.sw    = sw;
        e.delta = sw ^ fut_sw;
        e.chg   = |(sw ^ fut_sw);
        if ((e.press | e.rel) != 2'b00 || e.chg) q.push_back(e);
        fut_lvl = nl;
        fut_sw  = sw;
        BTN     = btn;
        SW      = sw;
    endtask

    task automatic do_reset(input int n);
        RST = 1'b1;
        q.delete();
        cur_lvl = '0;
        cur_sw  = '0;
        fut_lvl = '0;
        fut_sw  = '0;
        step(n);
        RST = 1'b0;
        apply(BTN, SW);
    endtask

    initial begin
        BTN = 2'b11;
        SW  = 10'h000;
        do_reset(2);
        step(10);                   // idle: everything stays 0

        apply(2'b10, 10'h000);      // press BTN[0]
        step(8);
        apply(2'b11, 10'h000);      // release BTN[0]
        step(8);

        BTN = 2'b01;                // 3-cycle glitch on BTN[1] must be ignored
        step(3);
        BTN = 2'b11;
        step(8);

        apply(2'b11, 10'h035);
        step(8);
        apply(2'b11, 10'h04A);
        step(8);

        apply(2'b00, 10'h04A);      // both buttons in the same cycle
        step(8);
        apply(2'b11, 10'h04A);
        step(8);

        apply(2'b10, 10'h04A);      // reset mid-count; switches held high through it
        step(2);
        do_reset(1);
        step(8);
        apply(2'b11, 10'h04A);
        step(8);

        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000 (10 ms at 50 MHz), meaning the number of consecutive cycles a synchronized input must differ from its stable value before the stable value updates; legal range >= 2.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 CLK1  input  1  system clock, all state updates on rising edge.
REQ-004 RST  input  1  synchronous active-high reset.
REQ-005 BTN  input  2  raw push buttons, active-low, asynchronous to CLK1.
REQ-006 SW  input  10  raw slide switches, asynchronous to CLK1.
REQ-007 BTN_LEVEL  output  2  debounced button state, active-high (1 = pressed).
REQ-008 BTN_PRESS  output  2  one-cycle pulse per bit on debounced press.
REQ-009 BTN_RELEASE  output  2  one-cycle pulse per bit on debounced release.
REQ-010 SW_STABLE  output  10  debounced switch state.
REQ-011 SW_DELTA  output  10  one-cycle mask of switch bits that changed stable value this cycle, else 0.
REQ-012 SW_CHANGE  output  1  one-cycle pulse, OR-reduction of SW_DELTA.

Function
REQ-013 Each of the 12 inputs SHALL pass through a two-flop synchronizer; BTN bits SHALL be inverted before the first flop.
REQ-014 Each bit SHALL own a counter of width clog2(DEBOUNCE_CYCLES): cleared when synchronized value equals stable value, incremented when it differs.
REQ-015 When counter equals DEBOUNCE_CYCLES-1 and the synchronized value still differs, the stable value SHALL take the synchronized value and the counter SHALL clear, on the same edge.
REQ-016 Latency: an input held constant from before edge k SHALL appear on the stable output after edge k+DEBOUNCE_CYCLES+1 (DEBOUNCE_CYCLES+2 edges total).
REQ-017 A change reverting before DEBOUNCE_CYCLES synchronized cycles SHALL clear the counter and produce no output change or pulse.
REQ-018 Pulses (BTN_PRESS, BTN_RELEASE, SW_DELTA, SW_CHANGE) SHALL be registered and asserted exactly in the cycle the corresponding stable value first shows its new value, for one cycle only.
REQ-019 BTN_PRESS[i] and BTN_RELEASE[i] SHALL never be asserted together.
REQ-020 Simultaneous stable updates on several bits SHALL assert all their pulses/DELTA bits in the same cycle; SW_CHANGE remains a single one-cycle pulse.
REQ-021 Bits SHALL be fully independent; no cross-bit priority or arbitration.

Reset
REQ-022 While RST is high on a clock edge, synchronizer flops, counters, stable values and all pulse registers SHALL clear to 0 (BTN_LEVEL=0 means released).
REQ-023 All outputs SHALL read 0 the cycle after a reset edge.
REQ-024 Reset asserted mid-count SHALL discard the count; debouncing restarts from the first non-reset edge with full DEBOUNCE_CYCLES+2 latency.
REQ-025 A switch held high through reset SHALL yield a SW_STABLE update and SW_DELTA/SW_CHANGE pulse DEBOUNCE_CYCLES+2 edges after RST deasserts.

Structure
REQ-026 Shared package SHALL hold N_BTN=2, N_SW=10 and DEFAULT_DEBOUNCE_CYCLES=500000.
REQ-027 One sub-module debounce_bit (synchronizer, counter, stable flop, rise/fall pulses) SHALL be instantiated N_BTN+N_SW times; input_conditioner adds inversion and SW_CHANGE reduction only.

Verification (DEBOUNCE_CYCLES=4, latency 6 edges, CLK1 period 20 ns)
REQ-028 RST high 2 cycles, BTN=2'b11, SW=10'h000 -> every output 0 for as long as inputs stay constant.
REQ-029 BTN[0] driven 0 and held -> BTN_LEVEL[0]=1 and BTN_PRESS[0]=1 for one cycle 6 edges later; BTN[0] back to 1 -> BTN_RELEASE[0] one-cycle pulse 6 edges later, BTN_LEVEL[0]=0.
REQ-030 BTN[1] low for 3 cycles then high -> BTN_LEVEL, BTN_PRESS, BTN_RELEASE stay 0.
REQ-031 SW 10'h000 -> 10'h035 held -> SW_STABLE=10'h035, SW_DELTA=10'h035 and SW_CHANGE=1 for one cycle; then SW -> 10'h04A -> SW_STABLE=10'h04A, SW_DELTA=10'h07F one cycle.
REQ-032 BTN=2'b00 applied in one cycle -> BTN_PRESS=2'b11 in the same single cycle.
REQ-033 BTN[0]=0 held, RST pulsed 1 cycle 2 edges later -> no press before reset; BTN_PRESS[0] pulses 6 edges after RST deasserts.
